// File: rtl/inertial_seq_if.sv
// SPI master handshake bundle for inertial_seq.
// master: the sequencer (issues wrt/cmd, consumes done/rd_data).
// slave:  the SPI master engine.
interface inertial_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inertial_seq.sv
// inertial_seq: sequencer for the 6-axis inertial sensor SPI link.
// Waits STARTUP_CYC clocks after reset, writes four config registers, then
// on each synchronised INT rise reads the sensor output registers and
// publishes 16-bit signed words with a one-cycle vld strobe.
// Build option: define INERT_AZ_EN to also read and publish az (0x2C/0x2D).
module inertial_seq #(
  parameter logic [15:0] STARTUP_CYC = 16'hFFFF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           INT,
  inertial_seq_if.master spi,
  output logic [15:0]    ptch,
  output logic [15:0]    roll,
  output logic [15:0]    yaw,
  output logic [15:0]    ax,
  output logic [15:0]    ay,
  output logic [15:0]    az,
  output logic           vld
);

`ifdef INERT_AZ_EN
  localparam int unsigned NUM_RD = 12;
`else
  localparam int unsigned NUM_RD = 10;
`endif
  localparam logic [3:0] LAST_RD  = 4'(NUM_RD - 1);
  localparam logic [1:0] LAST_CFG = 2'd3;
  localparam logic [6:0] RD_BASE  = 7'h22;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_WR, INIT_WAIT, IDLE, RD, RD_WAIT, PUBLISH
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic [1:0]  cfg_idx;
  logic [3:0]  rd_idx;
  logic        pending;
  logic        int_ff1, int_ff2, int_ff3;
  logic        int_rise;
  logic [7:0]  hold [0:NUM_RD-1];
  logic [15:0] cfg_word;
  logic [6:0]  rd_addr;
  logic        unused_rd_hi;

  // Only the response byte of the SPI word carries sensor data.
  assign unused_rd_hi = ^spi.rd_data[15:8];
  assign int_rise     = int_ff2 & ~int_ff3;

  // Two-flop synchroniser for INT plus one flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      int_ff3 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      int_ff3 <= int_ff2;
    end
  end

  // Config word table and read address for the current indices.
  always_comb begin
    cfg_word = 16'h0D02;
    unique case (cfg_idx)
      2'd0: cfg_word = 16'h0D02;
      2'd1: cfg_word = 16'h1062;
      2'd2: cfg_word = 16'h1162;
      2'd3: cfg_word = 16'h1460;
    endcase
    rd_addr = RD_BASE + {3'b000, rd_idx};
  end

  // Main sequencer with registered SPI request and data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PWR_WAIT;
      timer   <= '0;
      cfg_idx <= '0;
      rd_idx  <= '0;
      pending <= 1'b0;
      spi.wrt <= 1'b0;
      spi.cmd <= '0;
      vld     <= 1'b0;
      ptch    <= '0;
      roll    <= '0;
      yaw     <= '0;
      ax      <= '0;
      ay      <= '0;
`ifdef INERT_AZ_EN
      az      <= '0;
`endif
      for (int unsigned i = 0; i < NUM_RD; i++) hold[i] <= '0;
    end else begin
      spi.wrt <= 1'b0;
      vld     <= 1'b0;
      // Rises during a burst are remembered; rises before IDLE are dropped.
      if (int_rise && (state inside {RD, RD_WAIT, PUBLISH})) pending <= 1'b1;
      case (state)
        PWR_WAIT: begin
          if (timer == STARTUP_CYC) begin
            cfg_idx <= '0;
            state   <= INIT_WR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        INIT_WR: begin
          spi.wrt <= 1'b1;
          spi.cmd <= cfg_word;
          state   <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (spi.done) begin
            cfg_idx <= cfg_idx + 2'd1;
            state   <= (cfg_idx == LAST_CFG) ? IDLE : INIT_WR;
          end
        end
        IDLE: begin
          if (int_rise || pending) begin
            pending <= 1'b0;
            rd_idx  <= '0;
            state   <= RD;
          end
        end
        RD: begin
          spi.wrt <= 1'b1;
          spi.cmd <= {1'b1, rd_addr, 8'h00};
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (spi.done) begin
            hold[rd_idx] <= spi.rd_data[7:0];
            rd_idx       <= rd_idx + 4'd1;
            state        <= (rd_idx == LAST_RD) ? PUBLISH : RD;
          end
        end
        PUBLISH: begin
          ptch  <= {hold[1], hold[0]};
          roll  <= {hold[3], hold[2]};
          yaw   <= {hold[5], hold[4]};
          ax    <= {hold[7], hold[6]};
          ay    <= {hold[9], hold[8]};
`ifdef INERT_AZ_EN
          az    <= {hold[11], hold[10]};
`endif
          vld   <= 1'b1;
          state <= IDLE;
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

`ifndef INERT_AZ_EN
  assign az = '0;
`endif

endmodule

// File: tb/tb_inertial_seq.sv
// Testbench for inertial_seq: SPI slave model with command/response
// scoreboard queues, published-set scoreboard checked on vld.
module tb_inertial_seq;

`ifdef INERT_AZ_EN
  localparam int NRD = 12;
`else
  localparam int NRD = 10;
`endif
  localparam int LAT = 20;

  typedef struct {
    logic [15:0] p, r, y, x, yy, z;
  } set_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic INT = 1'b0;
  logic [15:0] ptch, roll, yaw, ax, ay, az;
  logic vld;

  inertial_seq_if bus ();

  inertial_seq #(.STARTUP_CYC(16'd16)) dut (
    .clk (clk), .rst (rst), .INT (INT), .spi (bus),
    .ptch(ptch), .roll(roll), .yaw(yaw), .ax(ax), .ay(ay), .az(az),
    .vld (vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wrt = 0;
  int n_rd = 0;
  int n_vld = 0;
  logic [15:0] last_cmd = '0;

  logic [15:0] exp_cmd_q [$];
  logic [7:0]  resp_q [$];
  set_t        set_q [$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // SPI slave model: checks each request against the expected command queue
  // and answers LAT clocks later with the next queued response byte.
  int   cnt = 0;
  int   stale_cnt = 0;
  logic busy = 1'b0;
  logic [7:0] resp = '0;
  initial begin
    bus.done    = 1'b0;
    bus.rd_data = '0;
  end
  always @(negedge clk) begin
    bus.done = 1'b0;
    if (rst) begin
      if (busy) stale_cnt = 4;
      busy = 1'b0;
    end else begin
      if (bus.wrt) begin
        n_wrt++;
        last_cmd = bus.cmd;
        check_eq("wrt_while_busy", {15'b0, busy}, 16'h0000);
        if (exp_cmd_q.size() == 0) check_eq("wrt_unexpected", {15'b0, bus.wrt}, 16'h0000);
        else check_eq("cmd", bus.cmd, exp_cmd_q.pop_front());
        if (bus.cmd[15]) begin
          n_rd++;
          resp = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hEE;
        end else begin
          resp = 8'h00;
        end
        busy = 1'b1;
        cnt  = LAT;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.done    = 1'b1;
          bus.rd_data = {8'hC3, resp};
          busy        = 1'b0;
        end
      end
      if (stale_cnt > 0) begin
        stale_cnt--;
        if (stale_cnt == 0) begin
          bus.done    = 1'b1;
          bus.rd_data = 16'hC3A5;
        end
      end
    end
  end

  // Output scoreboard: every vld pops one expected set; outside vld the
  // data outputs must hold.
  logic [95:0] prev_out = '0;
  logic        prev_vld = 1'b0;
  always @(negedge clk) begin
    logic [95:0] cur;
    set_t s;
    cur = {ptch, roll, yaw, ax, ay, az};
    if (rst) begin
      prev_out = cur;
      prev_vld = 1'b0;
    end else begin
      if (vld) begin
        n_vld++;
        check_eq("vld_width", {15'b0, prev_vld}, 16'h0000);
        if (set_q.size() == 0) begin
          check_eq("vld_unexpected", {15'b0, vld}, 16'h0000);
        end else begin
          s = set_q.pop_front();
          check_eq("ptch", ptch, s.p);
          check_eq("roll", roll, s.r);
          check_eq("yaw",  yaw,  s.y);
          check_eq("ax",   ax,   s.x);
          check_eq("ay",   ay,   s.yy);
          check_eq("az",   az,   s.z);
        end
      end else begin
        check_eq("data_hold", {15'b0, (cur !== prev_out)}, 16'h0000);
      end
      prev_out = cur;
      prev_vld = vld;
    end
  end

  task automatic push_config();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1062);
    exp_cmd_q.push_back(16'h1162);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic push_burst(input logic [15:0] p, r, y, x, yy, z);
    logic [15:0] w [6];
    logic [6:0]  a;
    set_t s;
    w = '{p, r, y, x, yy, z};
    for (int i = 0; i < NRD; i++) begin
      a = 7'h22 + 7'(i);
      exp_cmd_q.push_back({1'b1, a, 8'h00});
      resp_q.push_back((i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8]);
    end
    s.p = p; s.r = r; s.y = y; s.x = x; s.yy = yy;
    s.z = (NRD == 12) ? z : 16'h0000;
    set_q.push_back(s);
  endtask

  task automatic flush_queues();
    exp_cmd_q.delete();
    resp_q.delete();
    set_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wrt"}, {15'b0, bus.wrt}, 16'h0000);
    check_eq({tag, "_cmd"}, bus.cmd, 16'h0000);
    check_eq({tag, "_vld"}, {15'b0, vld}, 16'h0000);
    check_eq({tag, "_ptch"}, ptch, 16'h0000);
    check_eq({tag, "_roll"}, roll, 16'h0000);
    check_eq({tag, "_yaw"}, yaw, 16'h0000);
    check_eq({tag, "_ax"}, ax, 16'h0000);
    check_eq({tag, "_ay"}, ay, 16'h0000);
    check_eq({tag, "_az"}, az, 16'h0000);
  endtask

  // Releases reset and measures the clock count to the first request.
  task automatic reset_release(input string tag);
    int k;
    @(negedge clk);
    #2 rst = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.wrt) break;
    end
    check_eq(tag, 16'(k), 16'd18);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    for (k = 0; k < budget &&
         !(exp_cmd_q.size() == 0 && !busy && set_q.size() == 0 && stale_cnt == 0); k++)
      @(negedge clk);
    check_eq(tag, 16'(k < budget), 16'd1);
  endtask

  task automatic wait_rd(input int target, input string tag);
    int k;
    for (k = 0; k < 2000 && n_rd < target; k++) @(negedge clk);
    check_eq(tag, 16'(n_rd >= target), 16'd1);
  endtask

  task automatic pulse_int();
    @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  // Raises INT and bounds the delay to the first read request.
  task automatic int_and_measure(input string tag, input int max_lat);
    int k;
    @(negedge clk);
    INT = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.wrt) break;
    end
    check_eq(tag, 16'(k <= max_lat), 16'd1);
    repeat (2) @(negedge clk);
    INT = 1'b0;
  endtask

  initial begin
    int vbase, rbase, wbase, k;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    // Startup and configuration
    push_config();
    reset_release("startup_lat");
    wait_idle(300, "cfg_done");
    repeat (40) @(negedge clk);
    check_eq("cfg_wrt_count", 16'(n_wrt), 16'd4);

    // Single read burst
    push_burst(16'h1234, 16'h5678, 16'h9ABC, 16'h8001, 16'h7FFF, 16'h4000);
    int_and_measure("int_to_wrt_lat", 4);
    wait_idle(800, "burst1_done");
    check_eq("burst1_vld_count", 16'(n_vld), 16'd1);

    // INT rises mid-burst: one pending capture, one extra burst only
    vbase = n_vld;
    rbase = n_rd;
    push_burst(16'h0102, 16'h0304, 16'h0506, 16'hFFFE, 16'h8000, 16'h1111);
    push_burst(16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    pulse_int();
    wait_rd(rbase + 4, "pend_reach_rd4");
    pulse_int();
    wait_rd(rbase + 6, "pend_reach_rd6");
    pulse_int();
    for (k = 0; k < 800 && !vld; k++) @(negedge clk);
    check_eq("pend_first_vld", {15'b0, vld}, 16'h0001);
    for (k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (bus.wrt) break;
    end
    check_eq("vld_to_pending_wrt", 16'((k + 1) <= 3), 16'd1);
    wait_idle(800, "pend_done");
    repeat (100) @(negedge clk);
    check_eq("pend_vld_count", 16'(n_vld), 16'(vbase + 2));

    // INT already high through reset, startup and config
    @(negedge clk);
    #2 rst = 1'b1;
    INT = 1'b1;
    flush_queues();
    repeat (3) @(negedge clk);
    wbase = n_wrt;
    push_config();
    reset_release("early_startup_lat");
    wait_idle(300, "early_cfg_done");
    repeat (60) @(negedge clk);
    check_eq("early_no_read", 16'(n_wrt), 16'(wbase + 4));
    INT = 1'b0;
    repeat (5) @(negedge clk);
    vbase = n_vld;
    push_burst(16'h2468, 16'h1357, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0040);
    int_and_measure("early_fresh_lat", 4);
    wait_idle(800, "early_burst_done");
    check_eq("early_vld_count", 16'(n_vld), 16'(vbase + 1));

    // Reset while waiting on the 0xA600 read
    push_burst(16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222);
    pulse_int();
    for (k = 0; k < 800 && last_cmd != 16'hA600; k++) @(negedge clk);
    check_eq("midrd_reach_a600", last_cmd, 16'hA600);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrd_reset");
    flush_queues();
    repeat (2) @(negedge clk);
    push_config();
    reset_release("midrd_startup_lat");
    wait_idle(300, "midrd_cfg_done");
    repeat (40) @(negedge clk);
    vbase = n_vld;
    push_burst(16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, 16'h8796, 16'h4000);
    int_and_measure("midrd_burst_lat", 4);
    wait_idle(800, "midrd_burst_done");
    check_eq("midrd_vld_count", 16'(n_vld), 16'(vbase + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
